sdram_arbiter: RTL and testbench

// - Top-level sequencer for the SDRAM controller. Holds the bus idle until power-up init finishes.
// - Then grants the single SDRAM command/address/data bus to one of three engines: auto-refresh, write (burst writer) or read.
// - Owns the refresh interval timer. Drops write/read enables so a running burst ends and refresh can run.
// - Muxes the granted engine's cmd/addr/bank/dq onto the SDRAM pins.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_ref_timer.sv | 43 ++++
 rtl/sdram_arbiter.sv | 125 ++++++++++++
 tb/tb_sdram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, bus widths and arbiter states.
package sdram_pkg;

  localparam int unsigned CmdW  = 4;
  localparam int unsigned AddrW = 12;
  localparam int unsigned BankW = 2;
  localparam int unsigned DataW = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CmdW-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CmdW-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CmdW-1:0] CMD_RD   = 4'b0101;
  localparam logic [CmdW-1:0] CMD_WR   = 4'b0100;
  localparam logic [CmdW-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CmdW-1:0] CMD_AREF = 4'b0001;
  localparam logic [CmdW-1:0] CMD_MRS  = 4'b0000;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: free-runs once init is done and raises ref_req every REF_CYCLES.
module sdram_ref_timer #(
  parameter int unsigned REF_CYCLES = 780
) (
  input  logic sclk,
  input  logic srst_n,
  input  logic init_end,
  input  logic ref_done,
  output logic ref_req
);

  logic [9:0] cnt_q, cnt_d;
  logic       ref_req_q, ref_req_d;
  logic       wrap;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (!init_end) begin
      cnt_d = '0;
    end else if (cnt_q == 10'(REF_CYCLES - 1)) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + 10'd1;
    end
    // A wrap coinciding with ref_done keeps the request pending.
    ref_req_d = wrap | (ref_req_q & ~ref_done);
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      cnt_q     <= '0;
      ref_req_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ref_req_q <= ref_req_d;
    end
  end

  assign ref_req = ref_req_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus sequencer: holds off until init completes, then grants the bus to refresh,
// write or read engines and muxes the granted engine onto the SDRAM pins.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned REF_CYCLES = 780
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             init_end,
  input  logic [CmdW-1:0]  init_cmd,
  input  logic [AddrW-1:0] init_addr,
  output logic             ref_en,
  input  logic             ref_end,
  input  logic [CmdW-1:0]  ref_cmd,
  input  logic [AddrW-1:0] ref_addr,
  input  logic             wr_ask,
  output logic             wr_en,
  input  logic             wr_end,
  input  logic [CmdW-1:0]  wr_cmd,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [BankW-1:0] wr_bank,
  input  logic [DataW-1:0] wr_data,
  input  logic             wr_data_en,
  input  logic             rd_ask,
  output logic             rd_en,
  input  logic             rd_end,
  input  logic [CmdW-1:0]  rd_cmd,
  input  logic [AddrW-1:0] rd_addr,
  input  logic [BankW-1:0] rd_bank,
  output logic             sdram_cke,
  output logic [CmdW-1:0]  sdram_cmd,
  output logic [AddrW-1:0] sdram_addr,
  output logic [BankW-1:0] sdram_bank,
  output logic [DataW-1:0] sdram_dq_out,
  output logic             sdram_dq_oe
);

  state_e state_q, state_d;
  logic   last_wr_q, last_wr_d;
  logic   ref_req;
  logic   ref_done;

  // Only a refresh that actually holds the bus may retire the request.
  assign ref_done = ref_end & (state_q == S_AREF);

  sdram_ref_timer #(
    .REF_CYCLES(REF_CYCLES)
  ) u_ref_timer (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .init_end(init_end),
    .ref_done(ref_done),
    .ref_req (ref_req)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      S_INIT:  if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ref_req) begin
          state_d = S_AREF;
        end else if (wr_ask && (!rd_ask || !last_wr_q)) begin
          state_d   = S_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_ask) begin
          state_d   = S_READ;
          last_wr_d = 1'b0;
        end
      end
      S_AREF:  if (ref_end) state_d = S_ARBIT;
      S_WRITE: if (wr_end) state_d = S_ARBIT;
      S_READ:  if (rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q   <= S_INIT;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    unique case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

  // Dropping the grant while refresh is pending makes the engine stop after this burst.
  assign ref_en       = (state_q == S_AREF);
  assign wr_en        = (state_q == S_WRITE) & ~ref_req;
  assign rd_en        = (state_q == S_READ) & ~ref_req;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state_q == S_WRITE) & wr_data_en;
  assign sdram_cke    = 1'b1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized scoreboard bench for sdram_arbiter against a behavioural bus-ownership model.
module tb_sdram_arbiter;

  localparam int unsigned REF = 20;
  localparam int O_INIT = 0, O_ARB = 1, O_REF = 2, O_WR = 3, O_RD = 4;

  logic        sclk = 1'b0;
  logic        srst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = '0;
  logic [11:0] init_addr = '0;
  logic        ref_en;
  logic        ref_end = 1'b0;
  logic [3:0]  ref_cmd = '0;
  logic [11:0] ref_addr = '0;
  logic        wr_ask = 1'b0;
  logic        wr_en;
  logic        wr_end = 1'b0;
  logic [3:0]  wr_cmd = '0;
  logic [11:0] wr_addr = '0;
  logic [1:0]  wr_bank = '0;
  logic [15:0] wr_data = '0;
  logic        wr_data_en = 1'b0;
  logic        rd_ask = 1'b0;
  logic        rd_en;
  logic        rd_end = 1'b0;
  logic [3:0]  rd_cmd = '0;
  logic [11:0] rd_addr = '0;
  logic [1:0]  rd_bank = '0;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  always #5 sclk = ~sclk;

  sdram_arbiter #(
    .REF_CYCLES(REF)
  ) dut (
    .sclk        (sclk),
    .srst_n      (srst_n),
    .init_end    (init_end),
    .init_cmd    (init_cmd),
    .init_addr   (init_addr),
    .ref_en      (ref_en),
    .ref_end     (ref_end),
    .ref_cmd     (ref_cmd),
    .ref_addr    (ref_addr),
    .wr_ask      (wr_ask),
    .wr_en       (wr_en),
    .wr_end      (wr_end),
    .wr_cmd      (wr_cmd),
    .wr_addr     (wr_addr),
    .wr_bank     (wr_bank),
    .wr_data     (wr_data),
    .wr_data_en  (wr_data_en),
    .rd_ask      (rd_ask),
    .rd_en       (rd_en),
    .rd_end      (rd_end),
    .rd_cmd      (rd_cmd),
    .rd_addr     (rd_addr),
    .rd_bank     (rd_bank),
    .sdram_cke   (sdram_cke),
    .sdram_cmd   (sdram_cmd),
    .sdram_addr  (sdram_addr),
    .sdram_bank  (sdram_bank),
    .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe (sdram_dq_oe)
  );

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic [15:0] dq;
    logic        oe;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
  } bus_t;

  bus_t exp_q[$];
  int   cyc_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: who owns the bus, whether a refresh is owed, who was served last.
  int owner = O_INIT;
  bit pending = 1'b0;
  bit wrote_last = 1'b0;
  int n_edges = 0;

  // Engine stand-ins react to the model's ownership, not the DUT's.
  bit w_want = 1'b0, w_busy = 1'b0, r_want = 1'b0, r_busy = 1'b0, f_busy = 1'b0;
  int w_left = 0, r_left = 0, f_left = 0;
  int init_low_until = 203;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic bus_t model_out();
    bus_t e;
    e     = '0;
    e.cke = 1'b1;
    e.dq  = wr_data;
    case (owner)
      O_INIT: begin e.cmd = init_cmd; e.addr = init_addr; end
      O_ARB:  e.cmd = 4'b0111;
      O_REF:  begin e.cmd = ref_cmd; e.addr = ref_addr; e.ref_en = 1'b1; end
      O_WR: begin
        e.cmd = wr_cmd; e.addr = wr_addr; e.bank = wr_bank;
        e.oe = wr_data_en; e.wr_en = !pending;
      end
      O_RD: begin
        e.cmd = rd_cmd; e.addr = rd_addr; e.bank = rd_bank; e.rd_en = !pending;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    owner = O_INIT; pending = 1'b0; wrote_last = 1'b0; n_edges = 0;
    w_want = 1'b0; r_want = 1'b0; w_busy = 1'b0; r_busy = 1'b0; f_busy = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    bit wrap;
    wrap = 1'b0;
    if (init_end) begin
      n_edges++;
      wrap = (n_edges % REF) == 0;
    end else begin
      n_edges = 0;
    end
    nxt = owner;
    case (owner)
      O_INIT: if (init_end) nxt = O_ARB;
      O_ARB: begin
        if (pending) nxt = O_REF;
        else if (wr_ask && rd_ask) nxt = wrote_last ? O_RD : O_WR;
        else if (wr_ask) nxt = O_WR;
        else if (rd_ask) nxt = O_RD;
        if (nxt == O_WR) wrote_last = 1'b1;
        if (nxt == O_RD) wrote_last = 1'b0;
      end
      O_REF: if (ref_end) nxt = O_ARB;
      O_WR:  if (wr_end) nxt = O_ARB;
      O_RD:  if (rd_end) nxt = O_ARB;
      default: ;
    endcase
    pending = wrap || (pending && !(owner == O_REF && ref_end));
    owner   = nxt;
  endtask

  task automatic drive_inputs(input int cyc);
    init_end   = (cyc >= init_low_until);
    init_cmd   = init_end ? 4'($urandom) : 4'b0010;
    init_addr  = 12'($urandom);
    ref_cmd    = 4'($urandom);
    ref_addr   = 12'($urandom);
    wr_cmd     = 4'($urandom);
    wr_addr    = 12'($urandom);
    wr_bank    = 2'($urandom);
    wr_data    = 16'($urandom);
    wr_data_en = 1'($urandom);
    rd_cmd     = 4'($urandom);
    rd_addr    = 12'($urandom);
    rd_bank    = 2'($urandom);

    wr_end = 1'b0;
    if (owner == O_WR) begin
      if (!w_busy) begin w_busy = 1'b1; w_want = 1'b0; w_left = int'($urandom_range(8, 2)); end
      w_left--;
      if (w_left == 0) begin
        wr_end = 1'b1; w_busy = 1'b0; w_want = ($urandom_range(3, 0) != 0);
      end
    end else begin
      w_busy = 1'b0;
      wr_end = ($urandom_range(15, 0) == 0);
      if (!w_want) w_want = ($urandom_range(3, 0) == 0);
    end
    wr_ask = w_want;

    rd_end = 1'b0;
    if (owner == O_RD) begin
      if (!r_busy) begin r_busy = 1'b1; r_want = 1'b0; r_left = int'($urandom_range(8, 2)); end
      r_left--;
      if (r_left == 0) begin
        rd_end = 1'b1; r_busy = 1'b0; r_want = ($urandom_range(3, 0) != 0);
      end
    end else begin
      r_busy = 1'b0;
      rd_end = ($urandom_range(15, 0) == 0);
      if (!r_want) r_want = ($urandom_range(3, 0) == 0);
    end
    rd_ask = r_want;

    ref_end = 1'b0;
    if (owner == O_REF) begin
      if (!f_busy) begin f_busy = 1'b1; f_left = int'($urandom_range(5, 2)); end
      f_left--;
      if (f_left == 0) begin ref_end = 1'b1; f_busy = 1'b0; end
    end else begin
      f_busy  = 1'b0;
      ref_end = ($urandom_range(15, 0) == 0);
    end
  endtask

  // Monitor: compares the bus against the scoreboard once per cycle, mid-low-phase.
  initial begin
    bus_t got, want;
    int   c;
    forever begin
      @(negedge sclk);
      #2;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        c    = cyc_q.pop_front();
        got  = {sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out,
                sdram_dq_oe, ref_en, wr_en, rd_en};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL bus cyc=%0d got=%h want=%h", c, got, want);
        end
      end
    end
  end

  initial begin
    int rst_left;
    bit did_rst;
    rst_left = 3;
    did_rst  = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge sclk);
      drive_inputs(cyc);
      exp_q.push_back(model_out());
      cyc_q.push_back(cyc);
      if (!did_rst && cyc > 1500 && owner == O_RD && rst_left == 0) begin
        #3 srst_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_dq_oe", 32'(sdram_dq_oe), 32'd0);
        check("rst_cmd", 32'(sdram_cmd), 32'(init_cmd));
        check("rst_bank", 32'(sdram_bank), 32'd0);
        did_rst        = 1'b1;
        rst_left       = 2;
        init_low_until = cyc + 30;
        model_reset();
      end else if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) begin
          #3 srst_n = 1'b1;
          model_step();
        end
      end else begin
        model_step();
      end
    end
    @(negedge sclk);
    #3;
    if (!did_rst) check("reset_mid_read_reached", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
